periph_rx_arbiter: RTL and testbench
====================================

# periph_rx_arbiter

Collects receive traffic from all reconfigurable peripheral slots and merges it into the single USB-bound packet stream. Each slot's local RX FIFO, filled by the peripheral's `rx_data`/`rx_valid` port, is drained round-robin. The peripheral address is prepended to each payload word, and the full packet is written into the USB TX FIFO. It sits directly downstream of the per-slot RX FIFOs and upstream of the USB interface.

## Interface

Parameters:
- `usb_packet_width`, default 32: USB packet width in bits.
- `periph_address_width`, default 3: width of the address field.
- `num_peripherals`, default 8: number of slots; must be ≤ 2^`periph_address_width`.
- `burst_len`, default 4: maximum packets per grant; used only when `PERIPH_ARB_BURST_EN` is defined; minimum 1.

Ports (P = `usb_packet_width` − `periph_address_width`):
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `fifo_data`  in  `num_peripherals`*P  slot RX FIFO read data; slot i occupies bits [i*P +: P].
- `fifo_empty`  in  `num_peripherals`  per-slot RX FIFO empty flag.
- `fifo_read`  out  `num_peripherals`  per-slot read strobe; one-hot or zero.
- `usb_data`  out  `usb_packet_width`  packet to the USB TX FIFO.
- `usb_wr_en`  out  1  USB TX FIFO write strobe.
- `usb_full`  in  1  USB TX FIFO full flag.
- `idle`  out  1  no pending or in-flight traffic.

## Operation

- Slot RX FIFOs are standard (non-FWFT): data is valid on `fifo_data` the cycle after `fifo_read`.
- Packet format: `usb_data` = {address[`periph_address_width`-1:0], payload[P-1:0]}. The address sits in the MSBs and equals the slot index, zero-extended.
- FSM states and transitions:
  - ARB: scan slots starting at `last_grant`+1, wrapping modulo `num_peripherals`. Take the first slot with `fifo_empty` low, latch it as `grant`, clear the burst count, and go to READ. If no slot qualifies, stay in ARB.
  - READ: `fifo_read[grant]`=1 for exactly this cycle. Go to CAPTURE.
  - CAPTURE: register {grant, `fifo_data` slice} into `usb_data`. Go to SEND.
  - SEND: `usb_wr_en` = !`usb_full` (combinational). The block holds in SEND while `usb_full` is high. On the write cycle, increment the burst count and set `last_grant`=`grant`, then go to:
    - READ, if the burst option applies (see Configuration), or
    - ARB otherwise.
- Only this block reads the slot FIFOs, so the slot granted in ARB is guaranteed non-empty in READ. No underflow check is required.
- `usb_full` is sampled only in SEND. A read is never issued without a holding register to receive its data, so no word is dropped on backpressure.
- `idle` = (state==ARB) && &`fifo_empty`.
- Reset values:
  - state = ARB.
  - `last_grant` = `num_peripherals`−1, so slot 0 is served first.
  - `fifo_read` = 0, `usb_wr_en` = 0, `usb_data` = 0.
  - `idle` follows its equation.
- Reset mid-operation: a word already read in READ or CAPTURE, or held in SEND, is discarded. This is accepted behaviour; the host re-syncs after reset.

## Timing

- Latency: ARB decision in cycle T → `fifo_read` in T+1 → capture in T+2 → `usb_wr_en` in T+3 if `usb_full` is low.
- Peak throughput: one packet per 3 cycles per grant. Each new grant adds one ARB cycle.
- `usb_full` high for N cycles in SEND delays the write by exactly N cycles. `usb_data` stays stable throughout.
- `fifo_read` and `usb_wr_en` are never high in the same cycle.
- A simultaneous empty→non-empty transition on several slots in one cycle is resolved by round-robin order from `last_grant`+1.

## Configuration

- `PERIPH_ARB_BURST_EN` defined:
  - After a write in SEND, return to READ when the burst count < `burst_len` and `fifo_empty[grant]` is low.
  - Otherwise return to ARB.
  - The same slot keeps the grant for up to `burst_len` packets, at 3 cycles per packet.
- Not defined:
  - Every write returns to ARB, giving strict one-packet-per-grant round-robin.
  - `burst_len` is ignored.

## Test plan

- Reset, all slots empty → `idle`=1, `fifo_read`=0, `usb_wr_en`=0, `usb_data`=0 for 20 cycles.
- Slot 5 holds payload 0x0ABCDEF → `fifo_read[5]` in T+1, and `usb_wr_en` in T+3 with `usb_data`=0xA0ABCDEF (defaults).
- Slots 0, 2 and 7 each hold 2 words, burst disabled → packet address order 0,2,7,0,2,7; exactly 6 writes; then `idle`=1.
- Same stimulus with `PERIPH_ARB_BURST_EN` and `burst_len`=2 → address order 0,0,2,2,7,7.
- `usb_full` held high for 10 cycles during SEND → `usb_wr_en` stays 0 and `usb_data` is unchanged. The write occurs the cycle `usb_full` falls, with no extra `fifo_read` issued meanwhile.
- `rst` asserted during CAPTURE on slot 3 → state returns to ARB with outputs zero next cycle. The next packet served comes from slot 0 if that slot is non-empty.

Source files
------------

// File: rtl/periph_rx_arbiter.sv
// Round-robin drain of per-slot RX FIFOs into the USB TX FIFO, prefixing each payload with its slot address.
// Optional feature macro: PERIPH_ARB_BURST_EN (multi-packet grants of up to burst_len packets).
module periph_rx_arbiter #(
    parameter int unsigned usb_packet_width     = 32,
    parameter int unsigned periph_address_width = 3,
    parameter int unsigned num_peripherals      = 8,
    parameter int unsigned burst_len            = 4
) (
    input  logic                                                               clk,
    input  logic                                                               rst,
    input  logic [num_peripherals*(usb_packet_width-periph_address_width)-1:0] fifo_data,
    input  logic [num_peripherals-1:0]                                         fifo_empty,
    output logic [num_peripherals-1:0]                                         fifo_read,
    output logic [usb_packet_width-1:0]                                        usb_data,
    output logic                                                               usb_wr_en,
    input  logic                                                               usb_full,
    output logic                                                               idle
);

    localparam int unsigned aw        = periph_address_width;
    localparam int unsigned pw        = usb_packet_width - periph_address_width;
    localparam int unsigned burst_max = (burst_len < 1) ? 1 : burst_len;
    localparam int unsigned cw        = $clog2(burst_max + 1);
`ifdef PERIPH_ARB_BURST_EN
    localparam int unsigned burst_lim = burst_max;
`else
    localparam int unsigned burst_lim = 1;
`endif

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [aw-1:0]             grant_q, grant_d;
    logic [aw-1:0]             last_q, last_d;
    logic [cw-1:0]             cnt_q, cnt_d;
    logic [num_peripherals-1:0] read_d;
    logic [pw-1:0]             payload;
    logic                      found_hi, found_lo;
    logic [aw-1:0]             pick_hi, pick_lo;

    // Round-robin pick: first non-empty slot above last_grant, else first at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int unsigned i = 0; i < num_peripherals; i++) begin
            if (!fifo_empty[i] && (aw'(i) > last_q) && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = aw'(i);
            end
            if (!fifo_empty[i] && (aw'(i) <= last_q) && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = aw'(i);
            end
        end
    end

    // Granted slot's slice of the read-data bus.
    always_comb begin
        payload = '0;
        for (int unsigned i = 0; i < num_peripherals; i++) begin
            if (grant_q == aw'(i)) begin
                payload = fifo_data[i*pw +: pw];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB: begin
                if (found_hi || found_lo) begin
                    grant_d = found_hi ? pick_hi : pick_lo;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND: begin
                if (!usb_full) begin
                    cnt_d  = cw'(cnt_q + cw'(1));
                    last_d = grant_q;
                    // Stay on the same slot only while the burst allowance lasts and it still has data.
                    if ((cnt_d < cw'(burst_lim)) && !fifo_empty[grant_q]) begin
                        state_d = READ;
                    end else begin
                        state_d = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Read strobe is registered so it is high for exactly the READ cycle.
    always_comb begin
        read_d = '0;
        for (int unsigned i = 0; i < num_peripherals; i++) begin
            read_d[i] = (state_d == READ) && (grant_d == aw'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            grant_q   <= '0;
            last_q    <= aw'(num_peripherals - 1);
            cnt_q     <= '0;
            fifo_read <= '0;
            usb_data  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            fifo_read <= read_d;
            if (state_q == CAPTURE) begin
                usb_data <= {grant_q, payload};
            end
        end
    end

    assign usb_wr_en = (state_q == SEND) && !usb_full;
    assign idle      = (state_q == ARB) && (&fifo_empty);

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// Directed bench for periph_rx_arbiter: behavioural non-FWFT slot FIFOs, write monitor and expected-packet queue.
module tb_periph_rx_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 3;
    localparam int unsigned N  = 8;
    localparam int unsigned BL = 2;
    localparam int unsigned P  = W - AW;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*P-1:0] fifo_data = '0;
    logic [N-1:0]   fifo_empty;
    logic [N-1:0]   fifo_read;
    logic [W-1:0]   usb_data;
    logic           usb_wr_en;
    logic           usb_full;
    logic           idle;

    periph_rx_arbiter #(
        .usb_packet_width    (W),
        .periph_address_width(AW),
        .num_peripherals     (N),
        .burst_len           (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .usb_data  (usb_data),
        .usb_wr_en (usb_wr_en),
        .usb_full  (usb_full),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Slot FIFO model: data appears the cycle after the read strobe.
    logic [P-1:0] mem [N][16];
    int unsigned  wp [N] = '{default: 0};
    int unsigned  rp [N] = '{default: 0};
    logic [N-1:0] load_en;
    logic [P-1:0] load_word [N];
    int           rd_n = 0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (load_en[i]) begin
                mem[i][4'(wp[i])] <= load_word[i];
                wp[i]             <= wp[i] + 1;
            end
            if (fifo_read[i]) begin
                fifo_data[i*P +: P] <= mem[i][4'(rp[i])];
                rp[i]               <= rp[i] + 1;
            end
        end
        if (|fifo_read) rd_n <= rd_n + 1;
    end

    always_comb begin
        for (int i = 0; i < N; i++) fifo_empty[i] = (wp[i] == rp[i]);
    end

    // Write monitor, sampled mid-cycle.
    logic [W-1:0] wr_log [256];
    int           wr_n  = 0;
    int           ovl_n = 0;

    always @(negedge clk) begin
        if (usb_wr_en) begin
            wr_log[8'(wr_n)] <= usb_data;
            wr_n             <= wr_n + 1;
        end
        if (usb_wr_en && (|fifo_read)) ovl_n <= ovl_n + 1;
    end

    logic [W-1:0] exp_q [$];
    int           log_rd = 0;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] pk(input int unsigned s, input logic [P-1:0] w);
        return {AW'(s), w};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic load_one(input int unsigned s, input logic [P-1:0] w);
        load_en      = '0;
        load_en[s]   = 1'b1;
        load_word[s] = w;
        step();
        load_en = '0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int c;
        c = 0;
        while ((wr_n < n) && (c < budget)) begin
            step();
            c++;
        end
        check("write_timeout", 64'(wr_n >= n), 64'(1));
    endtask

    // Pop every expected packet and compare against the monitor log in order.
    task automatic drain(input string tag);
        logic [W-1:0] e;
        wait_writes(log_rd + exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 64'(wr_log[8'(log_rd)]), 64'(e));
            log_rd++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int slots [3];
        slots    = '{0, 2, 7};
        rst      = 1'b1;
        usb_full = 1'b0;
        load_en  = '0;
        for (int i = 0; i < N; i++) load_word[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state with every slot empty.
        for (int c = 0; c < 20; c++) begin
            check("rst_idle", 64'(idle), 64'(1));
            check("rst_read", 64'(fifo_read), 64'(0));
            check("rst_wr",   64'(usb_wr_en), 64'(0));
            check("rst_data", 64'(usb_data), 64'(0));
            step();
        end

        // Single packet latency on slot 5.
        load_one(5, P'(32'h0ABCDEF));
        exp_q.push_back(pk(5, P'(32'h0ABCDEF)));
        check("s5_t_read", 64'(fifo_read), 64'(0));
        check("s5_t_idle", 64'(idle), 64'(0));
        step();
        check("s5_t1_read", 64'(fifo_read), 64'(8'h20));
        check("s5_t1_wr",   64'(usb_wr_en), 64'(0));
        step();
        check("s5_t2_read", 64'(fifo_read), 64'(0));
        check("s5_t2_wr",   64'(usb_wr_en), 64'(0));
        step();
        check("s5_t3_wr",   64'(usb_wr_en), 64'(1));
        check("s5_t3_data", 64'(usb_data), 64'(32'hA0ABCDEF));
        drain("s5_pkt");
        repeat (4) step();
        check("s5_idle", 64'(idle), 64'(1));

        // Slots 0, 2, 7 with two words each, loaded simultaneously.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            load_en = '0;
            for (int k = 0; k < 3; k++) begin
                load_en[slots[k]]   = 1'b1;
                load_word[slots[k]] = P'(((slots[k] + 1) << 8) + r);
            end
            step();
        end
        load_en = '0;
`ifdef PERIPH_ARB_BURST_EN
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 2; r++)
                exp_q.push_back(pk(slots[k], P'(((slots[k] + 1) << 8) + r)));
`else
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++)
                exp_q.push_back(pk(slots[k], P'(((slots[k] + 1) << 8) + r)));
`endif
        drain("rr_order");
        repeat (6) step();
        check("rr_write_count", 64'(wr_n), 64'(log_rd));
        check("rr_idle", 64'(idle), 64'(1));

        // Backpressure: usb_full high for 10 cycles in SEND.
        do_reset();
        usb_full = 1'b1;
        load_one(1, P'(32'h1234567));
        exp_q.push_back(pk(1, P'(32'h1234567)));
        step();
        step();
        step();
        begin
            int rd_base;
            rd_base = rd_n;
            for (int c = 0; c < 10; c++) begin
                check("bp_wr_hold",   64'(usb_wr_en), 64'(0));
                check("bp_data_hold", 64'(usb_data), 64'(pk(1, P'(32'h1234567))));
                check("bp_read_hold", 64'(fifo_read), 64'(0));
                step();
            end
            usb_full = 1'b0;
            #1;
            check("bp_wr_release", 64'(usb_wr_en), 64'(1));
            step();
            check("bp_no_extra_read", 64'(rd_n - rd_base), 64'(0));
        end
        drain("bp_pkt");

        // Reset during CAPTURE on slot 3; slot 0 becomes non-empty meanwhile.
        do_reset();
        load_one(3, P'(32'h0333333));
        step();
        check("rc_read3", 64'(fifo_read), 64'(8'h08));
        step();
        rst          = 1'b1;
        load_en      = '0;
        load_en[0]   = 1'b1;
        load_word[0] = P'(32'h0000AAA);
        step();
        rst     = 1'b0;
        load_en = '0;
        check("rc_read",  64'(fifo_read), 64'(0));
        check("rc_wr",    64'(usb_wr_en), 64'(0));
        check("rc_data",  64'(usb_data), 64'(0));
        check("rc_idle",  64'(idle), 64'(0));
        exp_q.push_back(pk(0, P'(32'h0000AAA)));
        drain("rc_next_slot0");
        repeat (6) step();
        check("rc_write_count", 64'(wr_n), 64'(log_rd));
        check("no_read_write_overlap", 64'(ovl_n), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
